// File: rtl/ctrl_unit_pipe_if.sv
// ctrl_unit_pipe_if: IF-side handshake, flush and EX-side control bundle of the decode stage
interface ctrl_unit_pipe_if #(
  parameter int PC_W = 32
);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [PC_W-1:0] if_pc;
  logic            id_ready;
  logic            flush;
  logic            ex_ready;
  logic            ex_valid;
  logic [31:0]     ex_instr;
  logic [PC_W-1:0] ex_pc;
  logic [1:0]      ex_op_a_sel;
  logic            ex_op_b_sel;
  logic [3:0]      ex_alu_sel;
  logic [1:0]      ex_wb_sel;
  logic            ex_rd_wren;
  logic            ex_mem_wren;
  logic            ex_mem_rden;
  logic [2:0]      ex_lsu_op;
  logic            ex_is_branch;
  logic [2:0]      ex_br_type;
  logic            ex_br_unsigned;
  logic            ex_is_jump;
  logic            ex_illegal;
  modport master (
    output if_valid, if_instr, if_pc, flush, ex_ready,
    input  id_ready, ex_valid, ex_instr, ex_pc, ex_op_a_sel, ex_op_b_sel, ex_alu_sel, ex_wb_sel,
           ex_rd_wren, ex_mem_wren, ex_mem_rden, ex_lsu_op, ex_is_branch, ex_br_type,
           ex_br_unsigned, ex_is_jump, ex_illegal
  );
  modport slave (
    input  if_valid, if_instr, if_pc, flush, ex_ready,
    output id_ready, ex_valid, ex_instr, ex_pc, ex_op_a_sel, ex_op_b_sel, ex_alu_sel, ex_wb_sel,
           ex_rd_wren, ex_mem_wren, ex_mem_rden, ex_lsu_op, ex_is_branch, ex_br_type,
           ex_br_unsigned, ex_is_jump, ex_illegal
  );
endinterface

// File: rtl/ctrl_unit_pipe.sv
// ctrl_unit_pipe: RV32I decode/control stage between IF and EX with load-use bubble and flush
module ctrl_unit_pipe #(
  parameter int          PC_W           = 32,
  parameter bit          LOAD_USE_STALL = 1'b1,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
  input logic             clk,
  input logic             rst_n,
  ctrl_unit_pipe_if.slave bus
);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
                         OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13, OP_REG = 7'h33;
  typedef struct packed {
    logic [1:0] op_a_sel;
    logic       op_b_sel;
    logic [3:0] alu_sel;
    logic [1:0] wb_sel;
    logic       rd_wren;
    logic       mem_wren;
    logic       mem_rden;
    logic [2:0] lsu_op;
    logic       is_branch;
    logic [2:0] br_type;
    logic       br_unsigned;
    logic       is_jump;
    logic       illegal;
  } ctrl_t;
  logic            id_valid, ex_valid;
  logic [31:0]     id_instr, ex_instr;
  logic [PC_W-1:0] id_pc, ex_pc;
  ctrl_t           ex_ctrl, dec;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rd_id, rs1, rs2, rd_ex;
  logic            bad, rs1_used, rs2_used, hazard, ex_adv, id_ready, bubble;
  assign opc   = id_instr[6:0];
  assign rd_id = id_instr[11:7];
  assign f3    = id_instr[14:12];
  assign rs1   = id_instr[19:15];
  assign rs2   = id_instr[24:20];
  assign f7    = id_instr[31:25];
  assign rd_ex = ex_instr[11:7];
  function automatic logic [3:0] alu_of(input logic [2:0] f, input logic alt);
    case (f)
      3'd0:    alu_of = alt ? 4'd1 : 4'd0;
      3'd1:    alu_of = 4'd7;
      3'd2:    alu_of = 4'd2;
      3'd3:    alu_of = 4'd3;
      3'd4:    alu_of = 4'd4;
      3'd5:    alu_of = alt ? 4'd9 : 4'd8;
      3'd6:    alu_of = 4'd5;
      default: alu_of = 4'd6;
    endcase
  endfunction
  always_comb begin
    dec = '0;
    bad = 1'b0;
    case (opc)
      OP_LUI:   begin dec.op_a_sel = 2'd2; dec.op_b_sel = 1'b1; dec.rd_wren = 1'b1; end
      OP_AUIPC: begin dec.op_a_sel = 2'd1; dec.op_b_sel = 1'b1; dec.rd_wren = 1'b1; end
      OP_JAL:   begin dec.op_a_sel = 2'd1; dec.op_b_sel = 1'b1; dec.wb_sel = 2'd2; dec.rd_wren = 1'b1; dec.is_jump = 1'b1; end
      OP_JALR:  begin dec.op_b_sel = 1'b1; dec.wb_sel = 2'd2; dec.rd_wren = 1'b1; dec.is_jump = 1'b1; bad = f3 != 3'd0; end
      OP_BR: begin
        dec.op_a_sel = 2'd1; dec.op_b_sel = 1'b1; dec.is_branch = 1'b1;
        dec.br_type = f3; dec.br_unsigned = f3[1];
        bad = f3[2:1] == 2'b01;
      end
      OP_LD: begin
        dec.op_b_sel = 1'b1; dec.wb_sel = 2'd1; dec.rd_wren = 1'b1; dec.mem_rden = 1'b1; dec.lsu_op = f3;
        bad = f3 == 3'd3 || f3[2:1] == 2'b11;
      end
      OP_ST:    begin dec.op_b_sel = 1'b1; dec.mem_wren = 1'b1; dec.lsu_op = f3; bad = f3 > 3'd2; end
      OP_IMM: begin
        dec.op_b_sel = 1'b1; dec.rd_wren = 1'b1;
        dec.alu_sel = alu_of(f3, f3 == 3'd5 && id_instr[30]);
        bad = f3 == 3'd1 ? f7 != 7'h00 : (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      OP_REG: begin
        dec.rd_wren = 1'b1;
        dec.alu_sel = alu_of(f3, id_instr[30]);
        bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      default: bad = 1'b1;
    endcase
    if (rd_id == 5'd0) dec.rd_wren = 1'b0;
    if (bad) begin
      dec = '0;
      dec.illegal = 1'b1;
    end
  end
  // rs1 is an operand for everything except the upper-immediate forms and jal
  assign rs1_used = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
  assign rs2_used = opc == OP_REG || opc == OP_ST || opc == OP_BR;
  assign hazard   = LOAD_USE_STALL && id_valid && ex_valid && ex_ctrl.mem_rden && rd_ex != 5'd0 &&
                    ((rs1_used && rs1 == rd_ex) || (rs2_used && rs2 == rd_ex));
  assign ex_adv   = !ex_valid || bus.ex_ready;
  assign bubble   = hazard || !id_valid || bus.flush;
  assign id_ready = rst_n && !bus.flush && (!id_valid || (ex_adv && !hazard));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
      ex_valid <= 1'b0;
      ex_instr <= NOP_INSTR;
      ex_pc    <= '0;
      ex_ctrl  <= '0;
    end else begin
      if (bus.flush) id_valid <= 1'b0;
      else if (id_ready) begin
        id_valid <= bus.if_valid;
        if (bus.if_valid) begin
          id_instr <= bus.if_instr;
          id_pc    <= bus.if_pc;
        end
      end
      if (ex_adv) begin
        ex_valid <= !bubble;
        ex_instr <= bubble ? NOP_INSTR : id_instr;
        ex_pc    <= id_pc;
        ex_ctrl  <= bubble ? ctrl_t'('0) : dec;
      end
    end
  end
  assign bus.id_ready       = id_ready;
  assign bus.ex_valid       = ex_valid;
  assign bus.ex_instr       = ex_instr;
  assign bus.ex_pc          = ex_pc;
  assign bus.ex_op_a_sel    = ex_ctrl.op_a_sel;
  assign bus.ex_op_b_sel    = ex_ctrl.op_b_sel;
  assign bus.ex_alu_sel     = ex_ctrl.alu_sel;
  assign bus.ex_wb_sel      = ex_ctrl.wb_sel;
  assign bus.ex_rd_wren     = ex_ctrl.rd_wren;
  assign bus.ex_mem_wren    = ex_ctrl.mem_wren;
  assign bus.ex_mem_rden    = ex_ctrl.mem_rden;
  assign bus.ex_lsu_op      = ex_ctrl.lsu_op;
  assign bus.ex_is_branch   = ex_ctrl.is_branch;
  assign bus.ex_br_type     = ex_ctrl.br_type;
  assign bus.ex_br_unsigned = ex_ctrl.br_unsigned;
  assign bus.ex_is_jump     = ex_ctrl.is_jump;
  assign bus.ex_illegal     = ex_ctrl.illegal;
endmodule
